// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined carry-lookahead adder/subtractor
// One SLICE-bit lookahead slice per stage; the inter-slice carry is registered between stages.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int STAGES = WIDTH / SLICE;

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;
  assign w_b_eff   = op ? ~b : b;
  assign w_c0      = op | cin;

  // Returns {carry out, sum}; each carry is the flattened lookahead term, not a ripple.
  function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             c);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   cv;
    logic             acc;
    logic             run;
    g     = x & y;
    p     = x ^ y;
    cv    = '0;
    cv[0] = c;
    for (int i = 0; i < SLICE; i++) begin
      acc = g[i];
      run = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (run & g[j]);
        run = run & p[j];
      end
      cv[i+1] = acc | (run & c);
    end
    return {cv[SLICE], p ^ cv[SLICE-1:0]};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;
    logic [SLICE-1:0]    w_a_s;
    logic [SLICE-1:0]    w_b_s;
    logic                w_c_in;
    logic                w_v_in;
    logic [SLICE:0]      w_res;
    logic [LO+SLICE-1:0] w_sum_next;
    logic                r_valid;
    logic [LO+SLICE-1:0] r_sum;

    if (k == 0) begin : g_src
      assign w_a_s      = a[SLICE-1:0];
      assign w_b_s      = w_b_eff[SLICE-1:0];
      assign w_c_in     = w_c0;
      assign w_v_in     = in_valid;
      assign w_sum_next = w_res[SLICE-1:0];
    end else begin : g_src
      assign w_a_s      = g_stage[k-1].g_mid.r_a[SLICE-1:0];
      assign w_b_s      = g_stage[k-1].g_mid.r_b[SLICE-1:0];
      assign w_c_in     = g_stage[k-1].g_mid.r_carry;
      assign w_v_in     = g_stage[k-1].r_valid;
      assign w_sum_next = {w_res[SLICE-1:0], g_stage[k-1].r_sum};
    end

    assign w_res = cla_slice(w_a_s, w_b_s, w_c_in);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_sum   <= '0;
      end else if (w_advance) begin
        r_valid <= w_v_in;
        r_sum   <= w_sum_next;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      // Skew registers: operand bits not yet consumed by a slice.
      localparam int REM = WIDTH - LO - SLICE;
      logic [REM-1:0] w_a_up;
      logic [REM-1:0] w_b_up;
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;
      logic           r_carry;

      if (k == 0) begin : g_up
        assign w_a_up = a[WIDTH-1:SLICE];
        assign w_b_up = w_b_eff[WIDTH-1:SLICE];
      end else begin : g_up
        assign w_a_up = g_stage[k-1].g_mid.r_a[REM+SLICE-1:SLICE];
        assign w_b_up = g_stage[k-1].g_mid.r_b[REM+SLICE-1:SLICE];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a     <= '0;
          r_b     <= '0;
          r_carry <= 1'b0;
        end else if (w_advance) begin
          r_a     <= w_a_up;
          r_b     <= w_b_up;
          r_carry <= w_res[SLICE];
        end
      end
    end else begin : g_last
      logic r_cout;
      logic r_ovf;
      logic r_zero;
      logic r_neg;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
          r_neg  <= 1'b0;
        end else if (w_advance) begin
          r_cout <= w_res[SLICE];
          r_ovf  <= w_res[SLICE] ^ (w_res[SLICE-1] ^ w_a_s[SLICE-1] ^ w_b_s[SLICE-1]);
          r_zero <= ~|w_sum_next;
          r_neg  <= w_sum_next[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].g_last.r_cout;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;
  assign zero      = g_stage[STAGES-1].g_last.r_zero;
  assign neg       = g_stage[STAGES-1].g_last.r_neg;

endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath. It is the next generation of the 8-bit two-slice CLA: it is generalised to WIDTH bits built from SLICE-bit lookahead slices, with one slice evaluated per pipeline stage and the inter-slice carry registered between stages. It accepts one operation per cycle under a valid/ready handshake, supports add, subtract and add-with-carry, and returns sum plus ALU status flags to the execute stage.

## Interface
- WIDTH, 16: operand/result width. Must be a multiple of SLICE and at least SLICE.
- SLICE, 4: bits per lookahead slice. STAGES = WIDTH/SLICE.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/op valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  1  0 = add, 1 = subtract (A − B).
- cin  input  1  carry-in for add. Ignored when op=1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH−1].

## Operation
- Input conditioning at acceptance:
  - b_eff = op ? ~b : b.
  - c0 = op ? 1 : cin.
- Stage k (0..STAGES−1):
  - SLICE-bit CLA on a[k-slice] + b_eff[k-slice] + carry_k.
  - carry_0 = c0. carry_k+1 is registered.
- Skew registers carry the unprocessed upper operand slices forward. Deskew registers carry the completed lower sum slices forward. All slices of one operation emerge together.
- Each stage holds a valid bit. A bubble propagates as valid=0 and never produces out_valid.
- Global advance = ~out_valid | out_ready. When advance=0, every pipeline register (data and valid) holds.
- in_ready = advance, combinational. An input is accepted on a rising edge with in_valid & in_ready.
- Flags are computed in the final stage from the completed result:
  - cout = carry out of the top slice.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
  - neg = sum MSB.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (asynchronous assert, synchronous-release usage): all valid bits 0. sum, cout, ovf, zero and neg are 0. out_valid = 0. in_ready = 1 after reset.
- Latency: an input accepted at edge n gives out_valid=1 after edge n+STAGES−1 (STAGES cycles of registers, output register included). For WIDTH=16, SLICE=4 this is 4 cycles.
- Throughput: one op per cycle while out_ready=1.
- Stall:
  - While out_valid=1 & out_ready=0, the output and all flags are stable and in_ready=0.
  - Data resumes on the cycle out_ready returns. No op is lost or duplicated.
- Simultaneous acceptance and output handshake in one cycle: both take effect. The pipeline shifts by one.
- in_valid=0 with advance=1 inserts a bubble.
- rst_n asserted mid-operation: all in-flight ops are discarded immediately and outputs go to reset values. No partial result is emitted after release.
- WIDTH == SLICE: a single stage with latency 1.

## Test plan
All scenarios use WIDTH=16, SLICE=4.
- Add wrap: a=0xFFFF, b=0x0001, op=0, cin=0 -> after 4 cycles sum=0x0000, cout=1, zero=1, ovf=0, neg=0.
- Signed overflow: a=0x7FFF, b=0x0001, op=0 -> sum=0x8000, ovf=1, neg=1, cout=0. Also a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, cout=1, zero=1.
- Subtract borrow and carry-in ignore:
  - a=0x0005, b=0x0007, op=1, cin=0 -> sum=0xFFFE, cout=0, neg=1.
  - a=0x1234, b=0x1234, op=1, cin=1 -> sum=0x0000, cout=1, zero=1.
  - Add with carry: a=0x00FF, b=0x0000, cin=1 -> sum=0x0100.
- Back-to-back stream: 8 random ops on consecutive cycles with out_ready=1 -> 8 results on consecutive cycles starting at cycle 4, in order, matching a reference model.
- Backpressure: stream 6 ops and drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, output held stable, all 6 results delivered in order with no loss or duplication. Bubbles (in_valid=0) never yield out_valid.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight -> out_valid=0 and all outputs 0 immediately. After release, no stale results appear and a new op returns a correct result 4 cycles after acceptance.
